// File: rtl/regs_read_collector.sv
// Operand collector: accepts a request naming up to three register rows and reads each masked row
// through one synchronous read port. It then presents the collected rows until the consumer takes them.
module regs_read_collector #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [ADDR_W-1:0] io_in_addr0,
  input  logic [ADDR_W-1:0] io_in_addr1,
  input  logic [ADDR_W-1:0] io_in_addr2,
  input  logic [2:0]        io_in_mask,
  input  logic [7:0]        io_in_tag,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data0,
  output logic [DATA_W-1:0] io_out_data1,
  output logic [DATA_W-1:0] io_out_data2,
  output logic [2:0]        io_out_mask,
  output logic [7:0]        io_out_tag
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [NSRC-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [NSRC-1:0][DATA_W-1:0]   data_q, data_d;
  logic [NSRC-1:0]               mask_q, mask_d;
  logic [NSRC-1:0]               pend_q, pend_d;
  logic [7:0]                    tag_q, tag_d;
  logic                          cap_vld_q, cap_vld_d;
  logic [SEL_W-1:0]              cap_sel_q, cap_sel_d;
  logic                          en_q, en_d;
  logic [ADDR_W-1:0]             raddr_q, raddr_d;
  logic                          valid_q, valid_d;
  logic [SEL_W-1:0]              sel_now;
  logic [SEL_W-1:0]              sel_next;

  // Index of the lowest-numbered source still waiting to be issued.
  function automatic logic [SEL_W-1:0] lowest(input logic [NSRC-1:0] p);
    if (p[0])      return SEL_W'(0);
    else if (p[1]) return SEL_W'(1);
    else           return SEL_W'(2);
  endfunction

  assign io_in_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    tag_d     = tag_q;
    cap_vld_d = 1'b0;
    cap_sel_d = cap_sel_q;
    en_d      = 1'b0;
    raddr_d   = '0;
    valid_d   = 1'b0;
    sel_now   = lowest(pend_q);
    sel_next  = '0;

    // Row read in the previous cycle lands in the slot it was issued for.
    if (cap_vld_q) begin
      data_d[cap_sel_q] = mem_R0_data;
    end

    case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          addr_d  = {io_in_addr2, io_in_addr1, io_in_addr0};
          mask_d  = io_in_mask;
          tag_d   = io_in_tag;
          data_d  = '0;
          pend_d  = io_in_mask;
          state_d = (io_in_mask != '0) ? ISSUE : OUT;
        end
      end
      ISSUE: begin
        pend_d    = pend_q & ~NSRC'(3'b001 << sel_now);
        cap_vld_d = 1'b1;
        cap_sel_d = sel_now;
        if (pend_d == '0) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = OUT;
      end
      OUT: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read port and valid are registered, so they are derived from the next state.
    if (state_d == ISSUE) begin
      sel_next = lowest(pend_d);
      en_d     = 1'b1;
      raddr_d  = addr_d[sel_next];
    end
    valid_d = (state_d == OUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      tag_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_sel_q <= '0;
      en_q      <= 1'b0;
      raddr_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      tag_q     <= tag_d;
      cap_vld_q <= cap_vld_d;
      cap_sel_q <= cap_sel_d;
      en_q      <= en_d;
      raddr_q   <= raddr_d;
      valid_q   <= valid_d;
    end
  end

  assign mem_R0_en    = en_q;
  assign mem_R0_addr  = raddr_q;
  assign io_out_valid = valid_q;
  assign io_out_data0 = data_q[0];
  assign io_out_data1 = data_q[1];
  assign io_out_data2 = data_q[2];
  assign io_out_mask  = mask_q;
  assign io_out_tag   = tag_q;

endmodule

// File: tb/tb_regs_read_collector.sv
// Directed bench for regs_read_collector with a write-first synchronous register-file model.
module tb_regs_read_collector;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   a0, a1, a2;
  logic [2:0]   in_mask;
  logic [7:0]   in_tag;
  logic         mem_en;
  logic [7:0]   mem_addr;
  logic [255:0] rdata;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] d0, d1, d2;
  logic [2:0]   out_mask;
  logic [7:0]   out_tag;

  logic         we;
  logic [7:0]   wa;
  logic [255:0] wd;
  logic [255:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regs_read_collector #(.ADDR_W(8), .DATA_W(256)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_in_addr0(a0), .io_in_addr1(a1), .io_in_addr2(a2),
    .io_in_mask(in_mask), .io_in_tag(in_tag),
    .mem_R0_en(mem_en), .mem_R0_addr(mem_addr), .mem_R0_data(rdata),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_data0(d0), .io_out_data1(d1), .io_out_data2(d2),
    .io_out_mask(out_mask), .io_out_tag(out_tag)
  );

  function automatic logic [255:0] row(input int r);
    logic [7:0] b;
    b = 8'(r);
    return {32{b}};
  endfunction

  // Register file: reset preloads row r with byte r; a same-edge write is visible to the read.
  always @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 256; r++) mem[r] <= row(r);
    end else if (we) begin
      mem[wa] <= wd;
    end
    if (mem_en) rdata <= (we && !reset && wa == mem_addr) ? wd : mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string        nm;
    logic [2:0]   mask;
    logic [7:0]   a0, a1, a2, tag;
    int           lat;
    int           n;
    logic [7:0]   ia0, ia1, ia2;
    logic [255:0] e0, e1, e2;
    int           stall;
    bit           early;
    int           wr_cyc;
    logic [255:0] wr_val;
  } vec_t;

  localparam logic [255:0] V1 = {8{32'hCAFE_0001}};
  localparam logic [255:0] V2 = {8{32'hBEEF_0002}};

  task automatic run_vec(input vec_t v);
    logic [7:0] iss [4];
    logic [7:0] ea  [3];
    int cnt      = 0;
    int vcyc     = -1;
    int addr_bad = 0;
    ea[0] = v.ia0; ea[1] = v.ia1; ea[2] = v.ia2;
    @(negedge clock);
    in_valid = 1'b1; a0 = v.a0; a1 = v.a1; a2 = v.a2; in_mask = v.mask; in_tag = v.tag;
    chk({v.nm, "_in_ready"}, 256'(in_ready), 256'(1));
    if (v.early) out_ready = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      we = 1'b0;
      if (c == v.wr_cyc) begin we = 1'b1; wa = v.a0; wd = v.wr_val; end
      if (mem_en) begin
        if (cnt < 4) iss[cnt] = mem_addr;
        cnt++;
      end else if (mem_addr != 8'd0) begin
        addr_bad++;
      end
      if (out_valid) begin vcyc = c; break; end
    end
    we = 1'b0;
    chk({v.nm, "_valid_cycle"}, 256'(vcyc), 256'(v.lat));
    chk({v.nm, "_issue_count"}, 256'(cnt), 256'(v.n));
    for (int i = 0; i < v.n && i < cnt; i++) chk({v.nm, "_issue_addr"}, 256'(iss[i]), 256'(ea[i]));
    chk({v.nm, "_idle_addr_zero"}, 256'(addr_bad), 256'(0));
    chk({v.nm, "_data0"}, d0, v.e0);
    chk({v.nm, "_data1"}, d1, v.e1);
    chk({v.nm, "_data2"}, d2, v.e2);
    chk({v.nm, "_out_mask"}, 256'(out_mask), 256'(v.mask));
    chk({v.nm, "_out_tag"}, 256'(out_tag), 256'(v.tag));
    chk({v.nm, "_in_ready_out"}, 256'(in_ready), 256'(0));
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clock);
      chk({v.nm, "_stall_valid"}, 256'(out_valid), 256'(1));
      chk({v.nm, "_stall_in_ready"}, 256'(in_ready), 256'(0));
      chk({v.nm, "_stall_data"}, d0 ^ d1 ^ d2, v.e0 ^ v.e1 ^ v.e2);
      chk({v.nm, "_stall_tag"}, 256'({out_mask, out_tag}), 256'({v.mask, v.tag}));
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk({v.nm, "_post_valid"}, 256'(out_valid), 256'(0));
    chk({v.nm, "_post_in_ready"}, 256'(in_ready), 256'(1));
    out_ready = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"all3", 3'b111, 8'd5, 8'd6, 8'd7, 8'h11, 5, 3, 8'd5, 8'd6, 8'd7,
                row(5), row(6), row(7), 0, 1'b0, 0, '0};
    vecs[1] = '{"m101_stall", 3'b101, 8'd9, 8'h44, 8'd10, 8'h22, 4, 2, 8'd9, 8'd10, 8'd0,
                row(9), '0, row(10), 10, 1'b0, 0, '0};
    vecs[2] = '{"m000", 3'b000, 8'd1, 8'd2, 8'd3, 8'h3C, 1, 0, 8'd0, 8'd0, 8'd0,
                '0, '0, '0, 0, 1'b0, 0, '0};
    vecs[3] = '{"m010_early_rdy", 3'b010, 8'd1, 8'd2, 8'd3, 8'h33, 3, 1, 8'd2, 8'd0, 8'd0,
                '0, row(2), '0, 0, 1'b1, 0, '0};
    vecs[4] = '{"dup_addr", 3'b110, 8'd8, 8'd8, 8'd8, 8'h44, 4, 2, 8'd8, 8'd8, 8'd0,
                '0, row(8), row(8), 0, 1'b0, 0, '0};
    vecs[5] = '{"m011_edges", 3'b011, 8'd0, 8'd255, 8'd4, 8'hFF, 4, 2, 8'd0, 8'd255, 8'd0,
                row(0), row(255), '0, 0, 1'b0, 0, '0};
    vecs[6] = '{"wr_same_cycle", 3'b001, 8'd5, 8'd0, 8'd0, 8'h55, 3, 1, 8'd5, 8'd0, 8'd0,
                V1, '0, '0, 0, 1'b0, 1, V1};
    vecs[7] = '{"wr_next_cycle", 3'b001, 8'd5, 8'd0, 8'd0, 8'h66, 3, 1, 8'd5, 8'd0, 8'd0,
                V1, '0, '0, 0, 1'b0, 2, V2};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; we = 1'b0; wa = '0; wd = '0;
    a0 = '0; a1 = '0; a2 = '0; in_mask = '0; in_tag = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_mem_en", 256'({mem_en, mem_addr}), 256'(0));
    chk("rst_fields", 256'({out_mask, out_tag}), 256'(0));
    chk("rst_data", d0 | d1 | d2, '0);
    reset = 1'b0;
    #1 chk("rst_release_in_ready", 256'(in_ready), 256'(1));

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset landing on the second issue of a three-row request.
    @(negedge clock);
    in_valid = 1'b1; a0 = 8'd1; a1 = 8'd2; a2 = 8'd3; in_mask = 3'b111; in_tag = 8'h77;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst_second_issue", 256'({mem_en, mem_addr}), 256'({1'b1, 8'd2}));
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_mem_en", 256'(mem_en), 256'(0));
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
    reset = 1'b0;
    #1 chk("mid_rst_release_ready", 256'(in_ready), 256'(1));
    begin
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (out_valid || mem_en) seen++;
      end
      chk("mid_rst_no_output", 256'(seen), 256'(0));
    end
    chk("mid_rst_data_clear", d0 | d1 | d2, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regs_read_collector.md
REGS_READ_COLLECTOR -- requirements
Module: regs_read_collector

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register-row address width.
REQ-002 SHALL have parameter DATA_W, default 256, row width (8 lanes x 32 bits).
REQ-003 SHALL have port clock, in, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, in, 1: synchronous, active-high.
REQ-005 SHALL have port io_in_valid, in, 1: operand request valid.
REQ-006 SHALL have port io_in_ready, out, 1: request accepted when both valid and ready are high.
REQ-007 SHALL have ports io_in_addr0, io_in_addr1, io_in_addr2, in, ADDR_W each: source row addresses.
REQ-008 SHALL have port io_in_mask, in, 3: bit k set means source k is needed.
REQ-009 SHALL have port io_in_tag, in, 8: opaque instruction tag.
REQ-010 SHALL have port mem_R0_en, out, 1: read enable to the register-file read port.
REQ-011 SHALL have port mem_R0_addr, out, ADDR_W: read address.
REQ-012 SHALL have port mem_R0_data, in, DATA_W: row data, valid in the cycle after the issuing cycle.
REQ-013 SHALL have port io_out_valid, out, 1: collected operands valid.
REQ-014 SHALL have port io_out_ready, in, 1: consumer accepts.
REQ-015 SHALL have ports io_out_data0, io_out_data1, io_out_data2, out, DATA_W each: collected rows.
REQ-016 SHALL have ports io_out_mask, out, 3, and io_out_tag, out, 8: copies of the latched request fields.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE and OUT.
REQ-018 SHALL drive io_in_ready=1 only in IDLE with reset low; on accept it SHALL latch the addresses, mask and tag, and clear all data registers to 0.
REQ-019 SHALL, on accept, go to ISSUE if mask!=0, and otherwise go directly to OUT.
REQ-020 SHALL, in ISSUE, issue one read per cycle: mem_R0_en=1, mem_R0_addr = address of the lowest-index masked source not yet issued.
REQ-021 SHALL, in each cycle following an issue, register mem_R0_data into the data slot of the source issued in the previous cycle.
REQ-022 SHALL go from ISSUE to CAPTURE after the last masked source is issued; CAPTURE SHALL last exactly 1 cycle, capture the final row, then go to OUT.
REQ-023 SHALL, for n = popcount(mask) >= 1 and accept at the end of cycle 0, assert io_out_valid in cycle n+2; for n=0, in cycle 1.
REQ-024 SHALL drive mem_R0_en=0 and mem_R0_addr=0 in every non-issuing cycle.
REQ-025 SHALL read duplicate addresses once per masked source (no merging).
REQ-026 SHALL, in OUT, hold io_out_valid=1 and all io_out_* stable until io_out_ready=1, then return to IDLE on the next edge.
REQ-027 SHALL keep io_in_ready=0 in OUT, including the handshake cycle (no same-cycle re-accept).
REQ-028 SHALL drive the data output of each unmasked source as 0.
REQ-029 SHALL ignore io_out_ready outside OUT, and ignore io_in_valid outside IDLE.
REQ-030 SHALL return row data that reflects every register-file write committed at or before the rising edge that ends that row's issuing cycle.

Reset
REQ-031 SHALL, with reset high at an edge, enter IDLE, set io_out_valid=0, clear data, mask and tag registers to 0, and set mem_R0_en=0.
REQ-032 SHALL drive io_in_ready=0 while reset is high, and 1 in the first cycle after reset deasserts.
REQ-033 SHALL, on reset in any state (mid-issue, capture or output), discard the pending request with no output handshake.

Verification
REQ-034 SHALL pass: mask=3'b111, addrs 5/6/7 (rows preloaded with 0x05.., 0x06.., 0x07..) -> three issues in cycles 1..3 with addrs 5, 6, 7; io_out_valid in cycle 5 with data0/1/2 = rows 5/6/7.
REQ-035 SHALL pass: mask=3'b101, addrs 9/X/10 -> two issues (9, then 10); valid in cycle 4; data1=0; io_out_mask=3'b101.
REQ-036 SHALL pass: mask=3'b000, tag=0x3C -> no mem_R0_en pulse; valid in cycle 1; all data 0; io_out_tag=0x3C.
REQ-037 SHALL pass: io_out_ready held low for 10 cycles in OUT -> outputs stable and io_in_ready=0 throughout; ready=1 -> IDLE and io_in_ready=1 the next cycle.
REQ-038 SHALL pass: reset asserted in the cycle of the second issue -> next cycle mem_R0_en=0 and io_out_valid=0, and no output is ever produced for that request.
REQ-039 SHALL pass: write to row 5 in the issue cycle of addr 5 -> the new value is collected; a write in the following cycle -> the old value is collected.
